// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the shift-and-add multiplier engine.
//   - state_t   : controller FSM state (WAIT = idle/done, EXEC = one op in flight)
//   - ALU_*     : datapath ALU operation codes (aop)
//   - FN_*      : micro-op function codes (op[1:0] when op[4] = 0)
package mult_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SHR  = 2'b01;
    localparam logic [1:0] ALU_SHL  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] FN_MOV = 2'b00;
    localparam logic [1:0] FN_SHR = 2'b01;
    localparam logic [1:0] FN_SHL = 2'b10;
    localparam logic [1:0] FN_TST = 2'b11;

endpackage

// File: rtl/mult_datapath.sv
// datapath: three 16-bit registers R0..R2, a one-bit lsb flag and a small ALU.
// Ports:
//   clk   - rising-edge clock
//   Rd    - destination register index (3 = no register)
//   w     - register write enable
//   in    - immediate write value
//   sel   - write-data select: 1 = in, 0 = ALU output
//   Ri    - ALU operand A index (3 reads 0)
//   Rj    - ALU operand B index (3 reads 0)
//   lsb   - flag register, loaded from aout[0]
//   aop   - ALU operation (ADD / SHR / SHL / PASS)
//   loadb - load enable for lsb
//   out   - ALU output (aout)
// Registers and the flag are intentionally not reset; they hold X until written.
module datapath
    import mult_pkg::*;
(
    input  logic        clk,
    input  logic [1:0]  Rd,
    input  logic        w,
    input  logic [15:0] in,
    input  logic        sel,
    input  logic [1:0]  Ri,
    input  logic [1:0]  Rj,
    output logic        lsb,
    input  logic [1:0]  aop,
    input  logic        loadb,
    output logic [15:0] out
);

    logic [15:0] R0, R1, R2;
    logic [15:0] iout, jout, aout;
    logic [15:0] wdata;
    logic [2:0]  load;
    logic        aL;

    // One-hot write decode; Rd = 3 selects nothing.
    always_comb begin
        load = 3'b000;
        if (w) begin
            case (Rd)
                2'd0:    load = 3'b001;
                2'd1:    load = 3'b010;
                2'd2:    load = 3'b100;
                default: load = 3'b000;
            endcase
        end
    end

    always_comb begin
        case (Ri)
            2'd0:    iout = R0;
            2'd1:    iout = R1;
            2'd2:    iout = R2;
            default: iout = 16'h0000;
        endcase
    end

    always_comb begin
        case (Rj)
            2'd0:    jout = R0;
            2'd1:    jout = R1;
            2'd2:    jout = R2;
            default: jout = 16'h0000;
        endcase
    end

    always_comb begin
        case (aop)
            ALU_ADD:  aout = iout + jout;
            ALU_SHR:  aout = iout >> 1;
            ALU_SHL:  aout = iout << 1;
            default:  aout = iout;
        endcase
    end

    assign aL    = aout[0];
    assign wdata = sel ? in : aout;
    assign out   = aout;

    always_ff @(posedge clk) begin
        if (load[0]) R0 <= wdata;
        if (load[1]) R1 <= wdata;
        if (load[2]) R2 <= wdata;
        if (loadb)   lsb <= aL;
    end

endmodule

// File: rtl/mult.sv
// mult: controller for the shift-and-add multiplier engine.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset (forces WAIT, done = 1)
//   s     - start request, sampled in WAIT
//   op    - 5-bit micro-op, latched into ir when s is accepted
//   in    - 16-bit immediate (used combinationally by MOV during EXEC)
//   out   - datapath ALU output
//   done  - 1 in WAIT (idle / last op complete), 0 in EXEC
// Handshake: in WAIT, s = 1 at a rising edge accepts op and enters EXEC; the
// next edge performs the single write and returns to WAIT. The host holds
// in stable until done rises and may change op once done is back high.
module mult
    import mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [4:0]  op,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        done
);

    state_t      state;
    logic [4:0]  ir;

    logic [1:0]  Rd, Ri, Rj, aop;
    logic        w, sel, loadb;
    logic        lsb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT;
            ir    <= 5'b00000;
        end else begin
            case (state)
                WAIT: begin
                    if (s) begin
                        ir    <= op;
                        state <= EXEC;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

    assign done = (state == WAIT);

    // Decode from the latched op. Write strobes are only raised in EXEC so a
    // reset during EXEC drops them immediately and the write is aborted.
    always_comb begin
        Rd    = ir[3:2];
        Ri    = ir[3:2];
        Rj    = ir[1:0];
        aop   = ALU_PASS;
        w     = 1'b0;
        sel   = 1'b0;
        loadb = 1'b0;
        if (ir[4]) begin
            // ADDC: conditional on the flag captured by an earlier TST.
            aop = ALU_ADD;
            w   = (state == EXEC) && lsb;
        end else begin
            case (ir[1:0])
                FN_MOV: begin
                    sel = (state == EXEC);
                    w   = (state == EXEC);
                end
                FN_SHR: begin
                    aop = ALU_SHR;
                    w   = (state == EXEC);
                end
                FN_SHL: begin
                    aop = ALU_SHL;
                    w   = (state == EXEC);
                end
                default: begin
                    loadb = (state == EXEC);
                end
            endcase
        end
    end

    datapath DP (
        .clk   (clk),
        .Rd    (Rd),
        .w     (w),
        .in    (in),
        .sel   (sel),
        .Ri    (Ri),
        .Rj    (Rj),
        .lsb   (lsb),
        .aop   (aop),
        .loadb (loadb),
        .out   (out)
    );

endmodule

// File: tb/tb_mult.sv
module tb_mult;

    logic        clk;
    logic        reset;
    logic        s;
    logic [4:0]  op;
    logic [15:0] in;
    logic [15:0] out;
    logic        done;

    int tests_run;
    int tests_failed;

    // Reference model: architectural registers, index 3 is the constant zero.
    logic [15:0] m_r [0:3];
    logic        m_lsb;

    mult DUT (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .op    (op),
        .in    (in),
        .out   (out),
        .done  (done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Micro-op semantics from the instruction-set rules.
    task automatic model_apply(input logic [4:0] o, input logic [15:0] imm);
        int d;
        d = int'(o[3:2]);
        if (o[4]) begin
            if (m_lsb && d != 3) m_r[d] = m_r[d] + m_r[int'(o[1:0])];
        end else begin
            case (o[1:0])
                2'b00: if (d != 3) m_r[d] = imm;
                2'b01: if (d != 3) m_r[d] = m_r[d] >> 1;
                2'b10: if (d != 3) m_r[d] = m_r[d] << 1;
                default: m_lsb = m_r[d][0];
            endcase
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".R0"}, DUT.DP.R0, m_r[0]);
        check({tag, ".R1"}, DUT.DP.R1, m_r[1]);
        check({tag, ".R2"}, DUT.DP.R2, m_r[2]);
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done !== 1'b1) check("done_timeout", {15'b0, done}, 16'h0001);
    endtask

    // Driver: issue one op, check the two-edge handshake, update the model.
    // Called #1 after a rising edge; with hold = 1, s stays high into the next op.
    task automatic issue(input logic [4:0] o, input logic [15:0] imm, input bit hold);
        wait_done();
        op = o;
        in = imm;
        s  = 1'b1;
        @(posedge clk);
        #1;
        check("done_fall", {15'b0, done}, 16'h0000);
        @(posedge clk);
        #1;
        check("done_rise", {15'b0, done}, 16'h0001);
        if (!hold) s = 1'b0;
        model_apply(o, imm);
    endtask

    logic [15:0] r1_before;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_r[3] = 16'h0000;
        m_lsb  = 1'b0;
        reset = 1'b1;
        s     = 1'b0;
        op    = 5'b00000;
        in    = 16'h0000;

        // Reset asserted between clock edges: done rises without an edge.
        #1 reset = 1'b0;
        #2;
        check("reset_done_async", {15'b0, done}, 16'h0001);
        #10;
        check("reset_done_hold", {15'b0, done}, 16'h0001);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Load the operands.
        issue(5'b00000, 16'd6, 1'b0);
        check("mov_r0", DUT.DP.R0, 16'd6);
        issue(5'b00100, 16'd7, 1'b0);
        issue(5'b01000, 16'd0, 1'b0);
        check("mov_r1", DUT.DP.R1, 16'd7);
        check("mov_r2", DUT.DP.R2, 16'd0);

        // Multiply loop with s held high across every op.
        for (int pass = 1; pass <= 3; pass++) begin
            issue(5'b00011, 16'h0000, 1'b1);
            issue(5'b11001, 16'h0000, 1'b1);
            if (pass == 1) begin
                check("p1_lsb", {15'b0, DUT.DP.lsb}, 16'h0000);
                check("p1_r2", DUT.DP.R2, 16'd0);
            end else if (pass == 2) begin
                check("p2_lsb", {15'b0, DUT.DP.lsb}, 16'h0001);
                check("p2_r2", DUT.DP.R2, 16'd14);
            end else begin
                check("p3_lsb", {15'b0, DUT.DP.lsb}, 16'h0001);
                check("p3_r2", DUT.DP.R2, 16'd42);
            end
            issue(5'b00001, 16'h0000, 1'b1);
            issue(5'b00110, 16'h0000, 1'b1);
            if (pass == 1) begin
                check("p1_r0", DUT.DP.R0, 16'd3);
                check("p1_r1", DUT.DP.R1, 16'd14);
            end else if (pass == 2) begin
                check("p2_r0", DUT.DP.R0, 16'd1);
                check("p2_r1", DUT.DP.R1, 16'd28);
            end
            check_regs("loop");
        end
        s = 1'b0;

        // Reset during EXEC of SHL R1 aborts the write.
        wait_done();
        r1_before = DUT.DP.R1;
        op = 5'b00110;
        s  = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_exec", {15'b0, done}, 16'h0000);
        s = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("abort_done", {15'b0, done}, 16'h0001);
        check("abort_state", {15'b0, DUT.state}, 16'h0000);
        @(posedge clk);
        #1;
        check("abort_r1", DUT.DP.R1, r1_before);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_regs("abort");

        // Boundaries.
        issue(5'b00100, 16'h8000, 1'b0);
        issue(5'b00110, 16'h0000, 1'b0);
        check("shl_8000", DUT.DP.R1, 16'h0000);
        issue(5'b00000, 16'hFFFF, 1'b0);
        issue(5'b01000, 16'h0001, 1'b0);
        issue(5'b01011, 16'h0000, 1'b0);
        issue(5'b10010, 16'h0000, 1'b0);
        check("addc_wrap", DUT.DP.R0, 16'h0000);
        issue(5'b01100, 16'h1234, 1'b0);
        check_regs("mov_r3");

        // Randomised ops against the model; start from a known flag.
        issue(5'b00011, 16'h0000, 1'b0);
        for (int i = 0; i < 150; i++) begin
            issue(5'($urandom_range(0, 31)), 16'($urandom), 1'($urandom_range(0, 1)));
            check_regs("rand");
            check("rand.lsb", {15'b0, DUT.DP.lsb}, {15'b0, m_lsb});
        end
        s = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
